// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: captures a decoded instruction, resolves operand
// forwarding from EX/MEM and MEM/WB, generates the 4-bit ALU control code
// and presents registered ALUop/op1/op2 under a valid/ready handshake.
module ex_operand_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [XLEN-1:0]   in_imm,
   input  logic              in_use_imm,
   input  logic [1:0]        in_alu_sel,
   input  logic              in_rtype,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7b5,
   input  logic              fwd_mem_we,
   input  logic [REG_AW-1:0] fwd_mem_rd,
   input  logic [XLEN-1:0]   fwd_mem_data,
   input  logic              fwd_wb_we,
   input  logic [REG_AW-1:0] fwd_wb_rd,
   input  logic [XLEN-1:0]   fwd_wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        ALUop,
   output logic [XLEN-1:0]   op1,
   output logic [XLEN-1:0]   op2,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_illegal
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

   // Pipeline register state
   logic              valid_q,   valid_d;
   logic [3:0]        aluop_q,   aluop_d;
   logic [XLEN-1:0]   op1_q,     op1_d;
   logic [XLEN-1:0]   op2_q,     op2_d;
   logic [REG_AW-1:0] rd_q,      rd_d;
   logic              illegal_q, illegal_d;

   // Combinational capture-side values
   logic              accept_s;
   logic [XLEN-1:0]   rs1_fwd_s;
   logic [XLEN-1:0]   rs2_fwd_s;
   logic [XLEN-1:0]   op2_sel_s;
   logic [3:0]        aluop_s;
   logic              illegal_s;

   // Forwarding mux: EX/MEM wins over MEM/WB; x0 always reads the register file.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [XLEN-1:0]   rf_data,
      input logic              mem_we,
      input logic [REG_AW-1:0] mem_rd,
      input logic [XLEN-1:0]   mem_data,
      input logic              wb_we,
      input logic [REG_AW-1:0] wb_rd,
      input logic [XLEN-1:0]   wb_data
   );
      logic [XLEN-1:0] res;
      if (mem_we && (mem_rd == rs) && (rs != REG_ZERO)) begin
         res = mem_data;
      end else if (wb_we && (wb_rd == rs) && (rs != REG_ZERO)) begin
         res = wb_data;
      end else begin
         res = rf_data;
      end
      return res;
   endfunction

   assign in_ready = !valid_q || out_ready;
   assign accept_s = in_valid && in_ready && !flush;

   // Resolve forwarded source operands and the register/immediate choice for op2.
   always_comb begin
      rs1_fwd_s = fwd_sel(in_rs1, in_rs1_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_we, fwd_wb_rd, fwd_wb_data);
      rs2_fwd_s = fwd_sel(in_rs2, in_rs2_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_we, fwd_wb_rd, fwd_wb_data);
      if (in_use_imm) begin
         op2_sel_s = in_imm;
      end else begin
         op2_sel_s = rs2_fwd_s;
      end
   end

   // ALU control decode; unsupported functions fall back to ADD and flag illegal.
   always_comb begin
      aluop_s   = ALU_ADD;
      illegal_s = 1'b0;
      case (in_alu_sel)
         2'b00: aluop_s = ALU_ADD;
         2'b01: aluop_s = ALU_SUB;
         2'b10: begin
            case (in_funct3)
               3'b000: begin
                  // Bit 30 only means SUB for register-register ops (addi ignores it)
                  if (in_rtype && in_funct7b5) begin
                     aluop_s = ALU_SUB;
                  end else begin
                     aluop_s = ALU_ADD;
                  end
               end
               3'b110:  aluop_s = ALU_OR;
               3'b111:  aluop_s = ALU_AND;
               default: begin
                  aluop_s   = ALU_ADD;
                  illegal_s = 1'b1;
               end
            endcase
         end
         default: begin
            aluop_s   = ALU_ADD;
            illegal_s = 1'b1;
         end
      endcase
   end

   // Next-state for the single-entry register: flush > accept > drain > hold.
   always_comb begin
      valid_d   = valid_q;
      aluop_d   = aluop_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      rd_d      = rd_q;
      illegal_d = illegal_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept_s) begin
         valid_d   = 1'b1;
         aluop_d   = aluop_s;
         op1_d     = rs1_fwd_s;
         op2_d     = op2_sel_s;
         rd_d      = in_rd;
         illegal_d = illegal_s;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Pipeline register with synchronous reset to an idle ADD of zeros.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         aluop_q   <= ALU_ADD;
         op1_q     <= {XLEN{1'b0}};
         op2_q     <= {XLEN{1'b0}};
         rd_q      <= REG_ZERO;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         aluop_q   <= aluop_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         rd_q      <= rd_d;
         illegal_q <= illegal_d;
      end
   end

   assign out_valid   = valid_q;
   assign ALUop       = aluop_q;
   assign op1         = op1_q;
   assign op2         = op2_q;
   assign out_rd      = rd_q;
   assign out_illegal = illegal_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage.
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_use_imm;
   logic [1:0]  in_alu_sel;
   logic        in_rtype;
   logic [2:0]  in_funct3;
   logic        in_funct7b5;
   logic        fwd_mem_we, fwd_wb_we;
   logic [4:0]  fwd_mem_rd, fwd_wb_rd;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  ALUop;
   logic [31:0] op1, op2;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int err_cnt = 0;
   int chk_cnt = 0;

   ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_alu_sel(in_alu_sel), .in_rtype(in_rtype),
      .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .ALUop(ALUop), .op1(op1), .op2(op2), .out_rd(out_rd), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_rs1_data = 32'd0; in_rs2_data = 32'd0;
      in_imm = 32'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
      in_use_imm = 1'b0; in_alu_sel = 2'b00; in_rtype = 1'b0; in_funct3 = 3'b000;
      in_funct7b5 = 1'b0; fwd_mem_we = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'd0;
      fwd_wb_we = 1'b0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'd0; flush = 1'b0;
      out_ready = 1'b1;

      // Reset then idle
      tick(); tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_aluop", {28'd0, ALUop}, 32'h2);
      chk("rst_op1", op1, 32'd0);
      chk("rst_op2", op2, 32'd0);
      chk("rst_rd", {27'd0, out_rd}, 32'd0);
      chk("rst_ill", {31'd0, out_illegal}, 32'd0);
      chk("rst_inready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // R-type SUB
      in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd7;
      in_rs1_data = 32'd10; in_rs2_data = 32'd3;
      in_alu_sel = 2'b10; in_funct3 = 3'b000; in_rtype = 1'b1; in_funct7b5 = 1'b1;
      tick();
      chk("sub_valid", {31'd0, out_valid}, 32'd1);
      chk("sub_aluop", {28'd0, ALUop}, 32'h6);
      chk("sub_op1", op1, 32'd10);
      chk("sub_op2", op2, 32'd3);
      chk("sub_rd", {27'd0, out_rd}, 32'd7);

      // addi with bit 30 set: still ADD, immediate on op2
      in_rtype = 1'b0; in_use_imm = 1'b1; in_imm = 32'hFFFF_FFFC;
      tick();
      chk("addi_valid", {31'd0, out_valid}, 32'd1);
      chk("addi_aluop", {28'd0, ALUop}, 32'h2);
      chk("addi_op1", op1, 32'd10);
      chk("addi_op2", op2, 32'hFFFF_FFFC);
      in_use_imm = 1'b0; in_funct7b5 = 1'b0;

      // Forward priority: EX/MEM beats MEM/WB, on both sources
      in_alu_sel = 2'b00; in_rs1 = 5'd5; in_rs2 = 5'd5;
      fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'hAA;
      fwd_wb_we = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'hBB;
      tick();
      chk("fwd_mem_op1", op1, 32'hAA);
      chk("fwd_mem_op2", op2, 32'hAA);
      chk("fwd_add", {28'd0, ALUop}, 32'h2);
      fwd_mem_we = 1'b0;
      tick();
      chk("fwd_wb_op1", op1, 32'hBB);
      chk("fwd_wb_op2", op2, 32'hBB);
      fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd2;
      tick();
      chk("fwd_x0_op1", op1, 32'd10);
      chk("fwd_x0_op2", op2, 32'd3);
      fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;

      // Backpressure: capture OR, then stall with new data pending
      in_rs1 = 5'd1; in_alu_sel = 2'b10; in_funct3 = 3'b110;
      in_rs1_data = 32'h1234; in_rs2_data = 32'h5678; in_rd = 5'd9;
      tick();
      chk("or_aluop", {28'd0, ALUop}, 32'h1);
      chk("or_op1", op1, 32'h1234);
      out_ready = 1'b0; in_funct3 = 3'b111;
      in_rs1_data = 32'h1111; in_rs2_data = 32'h2222; in_rd = 5'd3;
      #1;
      chk("bp_inready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_inready_hold", {31'd0, in_ready}, 32'd0);
         chk("bp_aluop", {28'd0, ALUop}, 32'h1);
         chk("bp_op1", op1, 32'h1234);
         chk("bp_op2", op2, 32'h5678);
         chk("bp_rd", {27'd0, out_rd}, 32'd9);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("nb_valid", {31'd0, out_valid}, 32'd1);
      chk("nb_aluop", {28'd0, ALUop}, 32'h0);
      chk("nb_op1", op1, 32'h1111);
      chk("nb_op2", op2, 32'h2222);
      chk("nb_rd", {27'd0, out_rd}, 32'd3);

      // Drain
      in_valid = 1'b0;
      tick();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // Flush beats accept
      in_valid = 1'b1; in_alu_sel = 2'b01; in_rs1_data = 32'h50;
      tick();
      chk("pre_flush_aluop", {28'd0, ALUop}, 32'h6);
      flush = 1'b1; out_ready = 1'b0; in_alu_sel = 2'b00; in_rs1_data = 32'h60;
      tick();
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_op1", op1, 32'h50);
      chk("flush_aluop", {28'd0, ALUop}, 32'h6);
      flush = 1'b0; in_alu_sel = 2'b01; in_rs1_data = 32'h70;
      tick();
      chk("post_flush_op1", op1, 32'h70);
      // rst beats flush
      rst = 1'b1; flush = 1'b1;
      tick();
      chk("rstfl_valid", {31'd0, out_valid}, 32'd0);
      chk("rstfl_aluop", {28'd0, ALUop}, 32'h2);
      chk("rstfl_op1", op1, 32'd0);
      chk("rstfl_op2", op2, 32'd0);
      rst = 1'b0; flush = 1'b0; out_ready = 1'b1;

      // Illegal funct3, then legal AND, then reserved alu_sel
      in_alu_sel = 2'b10; in_funct3 = 3'b001;
      tick();
      chk("ill_aluop", {28'd0, ALUop}, 32'h2);
      chk("ill_flag", {31'd0, out_illegal}, 32'd1);
      in_funct3 = 3'b111;
      tick();
      chk("and_aluop", {28'd0, ALUop}, 32'h0);
      chk("and_ill", {31'd0, out_illegal}, 32'd0);
      in_alu_sel = 2'b11;
      tick();
      chk("rsv_aluop", {28'd0, ALUop}, 32'h2);
      chk("rsv_ill", {31'd0, out_illegal}, 32'd1);
      in_valid = 1'b0;
      tick();
      chk("end_valid", {31'd0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
